// File: rtl/instruction_memory_sync.sv
// Clocked instruction memory with a valid/ready fetch handshake, a fixed
// number of wait states for good fetches, error flagging for misaligned or
// out-of-range fetches, and a write port for program loading.
module instruction_memory_sync #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_instruction,
  output logic [XLEN-1:0] resp_addr,
  output logic            resp_error,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [31:0]     wr_data
);

  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-1:0] DepthX = XLEN'(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [31:0]       resp_instruction_q, resp_instruction_d;
  logic [XLEN-1:0]   resp_addr_q, resp_addr_d;
  logic              resp_error_q, resp_error_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              req_err;
  logic              enter_resp;
  logic [XLEN-1:0]   rd_addr;
  logic              rd_err;
  logic [IdxW-1:0]   rd_idx;
  logic              wr_in_range;
  logic [IdxW-1:0]   wr_idx;

  assign req_ready  = (state_q == StIdle) || ((state_q == StResp) && resp_ready);
  assign accept     = req_valid && req_ready;
  assign req_err    = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= DepthX);
  assign rd_idx     = rd_addr[IdxW+1:2];

  assign wr_in_range = (wr_addr >> 2) < DepthX;
  assign wr_idx      = wr_addr[IdxW+1:2];

  assign resp_valid       = (state_q == StResp);
  assign resp_instruction = resp_instruction_q;
  assign resp_addr        = resp_addr_q;
  assign resp_error       = resp_error_q;

  // Next-state: handshake, wait countdown and response capture on RESP entry.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    addr_d             = addr_q;
    resp_instruction_d = resp_instruction_q;
    resp_addr_d        = resp_addr_q;
    resp_error_d       = resp_error_q;
    enter_resp         = 1'b0;
    rd_addr            = addr_q;
    rd_err             = 1'b0;

    unique case (state_q)
      StIdle, StResp: begin
        if ((state_q == StResp) && resp_ready) begin
          state_d = StIdle;
        end
        if (accept) begin
          addr_d = req_addr;
          // Errors and zero-wait fetches complete on the acceptance edge.
          if (req_err || (WAIT_STATES == 0)) begin
            enter_resp = 1'b1;
            rd_addr    = req_addr;
            rd_err     = req_err;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          enter_resp = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Array is read combinationally from the pre-edge contents, so a
    // same-edge write to the same word returns the old data.
    if (enter_resp) begin
      state_d            = StResp;
      resp_instruction_d = rd_err ? NOP_WORD : mem_q[rd_idx];
      resp_addr_d        = rd_addr;
      resp_error_d       = rd_err;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      addr_q             <= '0;
      resp_instruction_q <= '0;
      resp_addr_q        <= '0;
      resp_error_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      addr_q             <= addr_d;
      resp_instruction_q <= resp_instruction_d;
      resp_addr_q        <= resp_addr_d;
      resp_error_q       <= resp_error_d;
    end
  end

  // Program-load write port; contents are not reset, out-of-range writes drop.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && wr_in_range) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Bench for instruction_memory_sync: a 2-wait-state, 1024-word instance and a
// zero-wait, 20-word instance share one stimulus stream; a latency-based
// model predicts both, plus directed literal checks on the first instance.
module tb_instruction_memory_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        a_req_ready, a_resp_valid, a_resp_error;
  logic [31:0] a_resp_instruction, a_resp_addr;
  logic        b_req_ready, b_resp_valid, b_resp_error;
  logic [31:0] b_resp_instruction, b_resp_addr;

  localparam logic [31:0] Nop = 32'h00000013;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] prog [4] = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00000013};

  always #5 clk = ~clk;

  instruction_memory_sync #(
    .XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2), .NOP_WORD(Nop)
  ) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_addr(req_addr), .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_instruction(a_resp_instruction), .resp_addr(a_resp_addr),
    .resp_error(a_resp_error), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  instruction_memory_sync #(
    .XLEN(32), .DEPTH_WORDS(20), .WAIT_STATES(0), .NOP_WORD(Nop)
  ) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_addr(req_addr), .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_instruction(b_resp_instruction), .resp_addr(b_resp_addr),
    .resp_error(b_resp_error), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // ---------------- behavioural model ----------------
  // A fetch is either answered at once (error or zero wait) or becomes due a
  // fixed number of edges after acceptance.
  logic [31:0] m_mem [2][1024];
  bit          m_pend [2];
  longint      m_due [2];
  logic [31:0] m_paddr [2];
  bit          m_rv [2];
  logic [31:0] m_ri [2];
  logic [31:0] m_ra [2];
  bit          m_re [2];
  longint      cyc = 0;

  function automatic int unsigned depth(input int i);
    return (i == 0) ? 1024 : 20;
  endfunction

  function automatic int unsigned ws(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit m_ready(input int i);
    return !m_pend[i] && (!m_rv[i] || resp_ready);
  endfunction

  task automatic m_answer(input int i, input logic [31:0] a, input bit e);
    m_rv[i] = 1'b1;
    m_ri[i] = e ? Nop : m_mem[i][int'(a >> 2)];
    m_ra[i] = a;
    m_re[i] = e;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pend[i] = 1'b0;
        m_rv[i]   = 1'b0;
        m_ri[i]   = '0;
        m_ra[i]   = '0;
        m_re[i]   = 1'b0;
      end else begin
        bit rdy;
        bit e;
        rdy = m_ready(i);
        if (m_rv[i] && resp_ready) m_rv[i] = 1'b0;
        if (req_valid && rdy) begin
          e = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= depth(i));
          if (e || ws(i) == 0) begin
            m_answer(i, req_addr, e);
          end else begin
            m_pend[i]  = 1'b1;
            m_due[i]   = cyc + longint'(ws(i));
            m_paddr[i] = req_addr;
          end
        end else if (m_pend[i] && cyc == m_due[i]) begin
          m_pend[i] = 1'b0;
          m_answer(i, m_paddr[i], 1'b0);
        end
        if (wr_en && (wr_addr >> 2) < depth(i)) m_mem[i][int'(wr_addr >> 2)] = wr_data;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int i, input logic rdy, input logic rv,
                           input logic [31:0] ri, input logic [31:0] ra, input logic re);
    check($sformatf("req_ready[%0d]", i), 32'(rdy), 32'(m_ready(i)));
    check($sformatf("resp_valid[%0d]", i), 32'(rv), 32'(m_rv[i]));
    check($sformatf("resp_instruction[%0d]", i), ri, m_ri[i]);
    check($sformatf("resp_addr[%0d]", i), ra, m_ra[i]);
    check($sformatf("resp_error[%0d]", i), 32'(re), 32'(m_re[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, a_req_ready, a_resp_valid, a_resp_instruction, a_resp_addr, a_resp_error);
      check_dut(1, b_req_ready, b_resp_valid, b_resp_instruction, b_resp_addr, b_resp_error);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Present a fetch until the first instance accepts it; returns just after that edge.
  task automatic accept(input logic [31:0] a);
    int g;
    g = 0;
    req_valid = 1'b1; req_addr = a;
    while (!m_ready(0) && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) begin
      total++; bad++;
      $display("FAIL accept_timeout: got busy want ready (addr %h)", a);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Edges from acceptance (inclusive) until resp_valid on the first instance.
  task automatic wait_resp(output int n);
    n = 1;
    while (!a_resp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_instr", a_resp_instruction, 32'd0);
    check("rst_addr", a_resp_addr, 32'd0);
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    rst = 1'b0; resp_ready = 1'b1;

    // Preload every word so no read is of uninitialised storage.
    for (int k = 0; k < 1024; k++) write_word(32'(k * 4), $urandom);
    for (int k = 0; k < 4; k++) write_word(32'(k * 4), prog[k]);

    // Single fetch at pc=4.
    accept(32'd4);
    check("b_w0_valid", 32'(b_resp_valid), 32'd1);
    check("b_w0_instr", b_resp_instruction, 32'h00a00113);
    wait_resp(n);
    check("pc4_latency", n, 32'd3);
    check("pc4_instr", a_resp_instruction, 32'h00a00113);
    check("pc4_addr", a_resp_addr, 32'd4);
    check("pc4_error", 32'(a_resp_error), 32'd0);
    check("model_pin_pc4", m_ri[0], 32'h00a00113);
    tick();

    // Back-to-back fetches with resp_ready held high.
    req_valid = 1'b1; req_addr = 32'd0;
    tick();
    for (int j = 0; j < 4; j++) begin
      wait_resp(n);
      check($sformatf("b2b%0d_latency", j), n, 32'd3);
      check($sformatf("b2b%0d_instr", j), a_resp_instruction, prog[j]);
      check($sformatf("b2b%0d_addr", j), a_resp_addr, 32'(4 * j));
      check($sformatf("b2b%0d_req_ready", j), 32'(a_req_ready), 32'd1);
      if (j < 3) req_addr = 32'(4 * (j + 1));
      else req_valid = 1'b0;
      tick();
    end

    // Misaligned and out-of-range fetches.
    accept(32'd6);
    wait_resp(n);
    check("mis_latency", n, 32'd1);
    check("mis_instr", a_resp_instruction, Nop);
    check("mis_error", 32'(a_resp_error), 32'd1);
    check("mis_addr", a_resp_addr, 32'd6);
    tick();
    accept(32'd4096);
    wait_resp(n);
    check("oor_latency", n, 32'd1);
    check("oor_instr", a_resp_instruction, Nop);
    check("oor_error", 32'(a_resp_error), 32'd1);
    check("oor_addr", a_resp_addr, 32'd4096);
    tick();

    // Stalled consumer: outputs hold, new addresses ignored.
    resp_ready = 1'b0;
    accept(32'd8);
    wait_resp(n);
    check("stall_latency", n, 32'd3);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_addr = $urandom & 32'h0000_0ffc;
      tick();
      check("stall_valid", 32'(a_resp_valid), 32'd1);
      check("stall_instr", a_resp_instruction, 32'h002081b3);
      check("stall_addr", a_resp_addr, 32'd8);
      check("stall_req_ready", 32'(a_req_ready), 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(a_req_ready), 32'd1);
    tick();

    // Write during WAIT is seen by the pending fetch.
    accept(32'd0);
    wr_en = 1'b1; wr_addr = 32'd0; wr_data = 32'hdeadbeef;
    tick();
    wr_en = 1'b0;
    wait_resp(n);
    check("wait_write_instr", a_resp_instruction, 32'hdeadbeef);
    tick();
    write_word(32'd0, 32'h00500093);

    // Write on the RESP-entry edge returns the old word.
    accept(32'd0);
    tick();
    wr_en = 1'b1; wr_addr = 32'd0; wr_data = 32'hdeadbeef;
    tick();
    wr_en = 1'b0;
    check("rbw_valid", 32'(a_resp_valid), 32'd1);
    check("rbw_instr", a_resp_instruction, 32'h00500093);
    tick();
    accept(32'd0);
    wait_resp(n);
    check("refetch_instr", a_resp_instruction, 32'hdeadbeef);
    tick();

    // Reset during WAIT abandons the fetch.
    accept(32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("postrst_req_ready", 32'(a_req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("postrst_no_resp", 32'(a_resp_valid), 32'd0);
      tick();
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int unsigned idx;
      idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 24) : $urandom_range(0, 1100);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = 32'(idx * 4) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      resp_ready = ($urandom_range(0, 3) != 0);
      wr_en      = ($urandom_range(0, 5) == 0);
      wr_addr    = 32'($urandom_range(0, 1100) * 4) | 32'($urandom_range(0, 3));
      wr_data    = $urandom;
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req_valid = 1'b0; wr_en = 1'b0; resp_ready = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
